// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray/binary conversion, depth derivation and parameter range-check macro
// shared by async_fifo_param and its pointer synchronisers.
`ifndef FIFO_PKG_MACROS
`define FIFO_PKG_MACROS
`define FIFO_RANGE_CHECK(lbl, val, lo, hi) \
  if (((val) < (lo)) || ((val) > (hi))) begin : lbl \
    $error("async_fifo_param: parameter out of range"); \
  end
`endif

package fifo_pkg;

  // Wide enough for any supported pointer (AW <= 12 -> 13 bits), with spare headroom.
  localparam int PTR_MAXW = 16;
  typedef logic [PTR_MAXW-1:0] ptr_wide_t;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
    ptr_wide_t b;
    b = g;
    for (int i = PTR_MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: two-flop synchroniser carrying a registered Gray pointer into the clk domain.
module gray_ptr_sync #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!RESET) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/async_fifo_param.sv
// async_fifo_param: dual-clock FIFO with Gray pointer crossing, thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word fall-through reads; otherwise reads have 1-cycle latency.
module async_fifo_param
  import fifo_pkg::*;
#(
  parameter int DW        = 16,
  parameter int AW        = 8,
  parameter int AF_THRESH = 240,
  parameter int AE_THRESH = 2
) (
  input  logic          wclk,
  input  logic          rclk,
  input  logic          RESET,
  input  logic [DW-1:0] din,
  input  logic          wr_en,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   wr_count,
  output logic          overflow,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          rd_valid,
  output logic          empty,
  output logic          almost_empty,
  output logic [AW:0]   rd_count,
  output logic          underflow
);
  localparam int DEPTH = depth_of(AW);
  localparam int PW    = AW + 1;
  localparam logic [AW:0] AF_T = PW'(AF_THRESH);
  localparam logic [AW:0] AE_T = PW'(AE_THRESH);

  `FIFO_RANGE_CHECK(g_chk_aw, AW, 2, 12)
  `FIFO_RANGE_CHECK(g_chk_af, AF_THRESH, 1, DEPTH)
  `FIFO_RANGE_CHECK(g_chk_ae, AE_THRESH, 0, DEPTH - 1)

  logic [DW-1:0] mem [DEPTH];

  logic [AW:0] wbin, wgray, wbin_next, wgray_next, rgray_w, rbin_w, wr_count_next;
  logic        wr_fire, full_next;
  logic [AW:0] rbin, rgray, rbin_next, rgray_next, wgray_r, wbin_r, rd_count_next;
  logic        ram_rd, empty_next, underflow_set;
  logic [1:0]  rrst_sync;
  logic        rrst_n;
  ptr_wide_t   wgray_nx_x, rbin_w_x, rgray_nx_x, wbin_r_x;
  logic        unused_hi;

  assign wr_fire       = wr_en & ~full;
  assign wbin_next     = wbin + PW'(wr_fire);
  assign wgray_nx_x    = bin2gray(ptr_wide_t'(wbin_next));
  assign wgray_next    = wgray_nx_x[AW:0];
  assign rbin_w_x      = gray2bin(ptr_wide_t'(rgray_w));
  assign rbin_w        = rbin_w_x[AW:0];
  // Full when the writer is exactly one lap ahead of the (possibly stale) read pointer.
  assign full_next     = (wgray_next == {~rgray_w[AW:AW-1], rgray_w[AW-2:0]});
  assign wr_count_next = wbin_next - rbin_w;

  always_ff @(posedge wclk) begin
    if (!RESET) begin
      wbin        <= '0;
      wgray       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wgray       <= wgray_next;
      full        <= full_next;
      almost_full <= (wr_count_next >= AF_T);
      wr_count    <= wr_count_next;
      overflow    <= overflow | (wr_en & full);
    end
  end

  always_ff @(posedge wclk) begin
    if (wr_fire) mem[wbin[AW-1:0]] <= din;
  end

  gray_ptr_sync #(.W(PW)) u_sync_r2w (.clk(wclk), .RESET(RESET),  .d(rgray), .q(rgray_w));
  gray_ptr_sync #(.W(PW)) u_sync_w2r (.clk(rclk), .RESET(rrst_n), .d(wgray), .q(wgray_r));

  always_ff @(posedge rclk) rrst_sync <= {rrst_sync[0], RESET};
  assign rrst_n = rrst_sync[1];

`ifdef FIFO_FWFT_EN
  // Refill the output register whenever it is free or being popped.
  assign ram_rd        = ~empty & (~rd_valid | rd_en);
  assign underflow_set = rd_en & ~rd_valid;
`else
  assign ram_rd        = rd_en & ~empty;
  assign underflow_set = rd_en & empty;
`endif

  assign rbin_next     = rbin + PW'(ram_rd);
  assign rgray_nx_x    = bin2gray(ptr_wide_t'(rbin_next));
  assign rgray_next    = rgray_nx_x[AW:0];
  assign wbin_r_x      = gray2bin(ptr_wide_t'(wgray_r));
  assign wbin_r        = wbin_r_x[AW:0];
  assign empty_next    = (rgray_next == wgray_r);
  assign rd_count_next = wbin_r - rbin_next;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin         <= '0;
      rgray        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      underflow    <= 1'b0;
      rd_valid     <= 1'b0;
      dout         <= '0;
    end else begin
      rbin         <= rbin_next;
      rgray        <= rgray_next;
      empty        <= empty_next;
      almost_empty <= (rd_count_next <= AE_T);
      rd_count     <= rd_count_next;
      underflow    <= underflow | underflow_set;
`ifdef FIFO_FWFT_EN
      if (ram_rd)     rd_valid <= 1'b1;
      else if (rd_en) rd_valid <= 1'b0;
`else
      rd_valid     <= ram_rd;
`endif
      if (ram_rd) dout <= mem[rbin[AW-1:0]];
    end
  end

  assign unused_hi = ^{wgray_nx_x[PTR_MAXW-1:PW], rbin_w_x[PTR_MAXW-1:PW],
                       rgray_nx_x[PTR_MAXW-1:PW], wbin_r_x[PTR_MAXW-1:PW]};
endmodule
